// File: rtl/router_reg.sv
// rtl/router_reg.sv - Router 1x3 datapath register stage: header/payload latch, stall buffer, running parity
module router_reg #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  pkt_valid,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  fifo_full,
    input  logic                  detect_add,
    input  logic                  lfd_state,
    input  logic                  ld_state,
    input  logic                  laf_state,
    input  logic                  full_state,
    input  logic                  rst_int_reg,
    output logic                  parity_done,
    output logic                  low_packet_valid,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic [DATA_WIDTH-1:0] header_q, header_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic [DATA_WIDTH-1:0] int_parity_q, int_parity_d;
    logic [DATA_WIDTH-1:0] pkt_parity_q, pkt_parity_d;
    logic                  parity_done_q, parity_done_d;
    logic                  low_pv_q, low_pv_d;
    logic                  err_q, err_d;

    // Address 2'b11 names no output port, so such a header is never captured.
    logic addr_ok;
    assign addr_ok = (data_in[1:0] != 2'b11);

    // The parity byte is the one arriving in LOAD_DATA with pkt_valid low.
    logic last_byte;
    assign last_byte = ld_state && !pkt_valid;

    // Header capture during address decode.
    always_comb begin
        header_d = header_q;
        if (detect_add && pkt_valid && addr_ok) begin
            header_d = data_in;
        end
    end

    // Byte presented to the FIFO: header first, then live payload, then the replayed stalled byte.
    always_comb begin
        dout_d = dout_q;
        if (lfd_state) begin
            dout_d = header_q;
        end else if (ld_state && !fifo_full) begin
            dout_d = data_in;
        end else if (laf_state) begin
            dout_d = hold_q;
        end
    end

    // Keep the byte that a full FIFO refused so LOAD_AFTER_FULL can replay it.
    always_comb begin
        hold_d = hold_q;
        if (ld_state && fifo_full) begin
            hold_d = data_in;
        end
    end

    // Running XOR over header and payload; a stalled byte is counted when first seen, not on replay.
    always_comb begin
        int_parity_d = int_parity_q;
        if (detect_add) begin
            int_parity_d = '0;
        end else if (lfd_state) begin
            int_parity_d = int_parity_q ^ header_q;
        end else if (ld_state && pkt_valid) begin
            int_parity_d = int_parity_q ^ data_in;
        end
    end

    // Parity byte sent by the source.
    always_comb begin
        pkt_parity_d = pkt_parity_q;
        if (detect_add) begin
            pkt_parity_d = '0;
        end else if (last_byte) begin
            pkt_parity_d = data_in;
        end
    end

    // low_packet_valid: set on the parity byte, cleared by the FSM's internal register clear; set wins.
    always_comb begin
        low_pv_d = low_pv_q;
        if (last_byte) begin
            low_pv_d = 1'b1;
        end else if (rst_int_reg) begin
            low_pv_d = 1'b0;
        end
    end

    // parity_done: parity byte written directly, or replayed after a full stall; set wins over clear.
    always_comb begin
        parity_done_d = parity_done_q;
        if ((last_byte && !fifo_full) || (laf_state && low_pv_q && !parity_done_q)) begin
            parity_done_d = 1'b1;
        end else if (detect_add) begin
            parity_done_d = 1'b0;
        end
    end

    // err: compare the finished parities once parity_done is up; a new packet clears it.
    always_comb begin
        err_d = err_q;
        if (detect_add) begin
            err_d = 1'b0;
        end else if (parity_done_q && (int_parity_q != pkt_parity_q)) begin
            err_d = 1'b1;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dout_q        <= '0;
            header_q      <= '0;
            hold_q        <= '0;
            int_parity_q  <= '0;
            pkt_parity_q  <= '0;
            parity_done_q <= 1'b0;
            low_pv_q      <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            dout_q        <= dout_d;
            header_q      <= header_d;
            hold_q        <= hold_d;
            int_parity_q  <= int_parity_d;
            pkt_parity_q  <= pkt_parity_d;
            parity_done_q <= parity_done_d;
            low_pv_q      <= low_pv_d;
            err_q         <= err_d;
        end
    end

    assign dout             = dout_q;
    assign parity_done      = parity_done_q;
    assign low_packet_valid = low_pv_q;
    assign err              = err_q;

endmodule

// File: doc/router_reg.md
Name: router_reg

Overview:
- Datapath register stage directly downstream of router_fsm in the Router 1x3.
- Consumes the FSM state strobes and latches the header and payload bytes, presenting them on dout to the FIFO write path.
- Buffers the byte stalled by a full FIFO and accumulates running XOR parity.
- Reports parity_done, low_packet_valid and a parity error back to the FSM and top level.

Parameters:
- DATA_WIDTH, 8, width of data_in/dout and of every parity and holding register; header bits [1:0] are the destination address.

Ports:
- clock  input  1  single system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- pkt_valid  input  1  source byte valid; deasserts on the parity byte
- data_in  input  DATA_WIDTH  source byte (header, payload, parity)
- fifo_full  input  1  selected destination FIFO is full this cycle
- detect_add  input  1  FSM in DECODE_ADDRESS
- lfd_state  input  1  FSM in LOAD_FIRST_DATA
- ld_state  input  1  FSM in LOAD_DATA
- laf_state  input  1  FSM in LOAD_AFTER_FULL
- full_state  input  1  FSM in FIFO_FULL_STATE
- rst_int_reg  input  1  FSM in CHECK_PARITY_ERROR (internal register clear)
- parity_done  output  1  parity byte has been accepted into dout
- low_packet_valid  output  1  pkt_valid fell while in LOAD_DATA
- err  output  1  packet parity mismatch
- dout  output  DATA_WIDTH  byte to FIFO write port

Behaviour:
- Reset:
  - reset=1 asynchronously clears dout, header_reg, hold_reg, internal_parity, packet_parity, parity_done, low_packet_valid and err to 0.
  - Reset mid-packet discards all packet state. No output changes until the next detect_add.
- header_reg:
  - Loads data_in when detect_add && pkt_valid && data_in[1:0]!=2'b11.
  - Otherwise holds.
  - Address 2'b11 is never latched.
- dout, priority order:
  - lfd_state: dout<=header_reg (1-cycle latency from detect_add capture).
  - ld_state && !fifo_full: dout<=data_in.
  - laf_state: dout<=hold_reg.
  - All other cases hold.
- hold_reg: loads data_in when ld_state && fifo_full. This is the byte that could not be written, and it is replayed in LOAD_AFTER_FULL.
- internal_parity:
  - Cleared on detect_add.
  - lfd_state: ^=header_reg.
  - ld_state && pkt_valid: ^=data_in, regardless of fifo_full; the stalled byte is counted once.
  - full_state and laf_state: no update.
- packet_parity: loads data_in when ld_state && !pkt_valid. Cleared on detect_add.
- low_packet_valid:
  - Set when ld_state && !pkt_valid.
  - Cleared on rst_int_reg.
  - Set has priority if both occur in the same cycle.
- parity_done:
  - Set when ld_state && !fifo_full && !pkt_valid.
  - Also set when laf_state && low_packet_valid && !parity_done (parity byte was stalled by full).
  - Cleared on detect_add.
  - Set and clear cannot coincide; if they do, set wins.
- err:
  - Set on the edge after parity_done=1 when internal_parity!=packet_parity.
  - Cleared on detect_add.
  - Otherwise holds and stays asserted through CHECK_PARITY_ERROR.
- Simultaneous fifo_full and last byte in ld_state:
  - The parity byte goes to hold_reg and packet_parity together.
  - low_packet_valid sets; parity_done waits for laf_state.
- State strobes are one-hot from the FSM; overlap is undefined. The implementation applies the priority above.
- No combinational path from inputs to outputs. All outputs are registered.

Test Plan:
- Reset: assert reset mid-LOAD_DATA with dout=8'hA5 -> dout, err, parity_done and low_packet_valid all 0 immediately, without waiting for a clock edge.
- Good packet:
  - Stimulus: header 8'h0C (addr 0, len 3), payload 01,02,03, parity 8'h0C, no full.
  - Required: dout sequence 0C,01,02,03,0C.
  - Required: parity_done=1 the edge after the parity byte; low_packet_valid=1; err=0.
- Bad parity: same packet with parity byte 8'h0D -> err=1 one cycle after parity_done; err cleared on next detect_add.
- Full mid-payload:
  - Stimulus: fifo_full=1 while ld_state with data_in=8'h02, then FFS, then laf_state.
  - Required: hold_reg=02; dout=02 after laf_state; internal_parity counts 02 exactly once; final err=0.
- Full on parity byte:
  - Stimulus: fifo_full=1 while ld_state, pkt_valid=0, data_in=8'h0C.
  - Required: parity_done stays 0 until laf_state, then 1; dout=0C; low_packet_valid=1 until rst_int_reg.
- Invalid address: detect_add && pkt_valid with data_in=8'h0F -> header_reg unchanged; dout unchanged.
